// File: rtl/j1_iobus.sv
// ----------------------------------------------------------------------------
// j1_iobus
//
// I/O subsystem for the J1 SoC. It replaces the hand-wired I/O decode in the
// top level. All logic runs on the rising edge of clk. resetq is a
// synchronous, active-low reset.
//
// Contents:
//   - registered strobe/address stage (io_rd_, io_wr_, a, dout_)
//   - GPIO with per-bit direction and a two-flop input synchroniser
//   - LED register
//   - free-running cycle counter with a 16-bit-word snapshot
//   - receive FIFO between the UART and the CPU
//
// Ports:
//   clk, resetq                 clock and synchronous active-low reset
//   io_rd, io_wr                CPU I/O strobes (cycle N)
//   mem_addr, dout              I/O address and write data (cycle N)
//   io_din                      read data to the CPU (valid in cycle N+1)
//   gpio_in                     asynchronous pin inputs
//   gpio_out, gpio_oe           pin output values / output enables (1 = drive)
//   leds                        LED drive
//   uart_rx_valid/data/ack      UART receive side
//   uart_tx_busy/wr/data        UART transmit side
//
// Address decode is one-hot on the registered address a:
//   a[0]  gpio_in (r) / gpio_out (w)
//   a[1]  gpio_oe (r/w)
//   a[2]  leds    (r/w)
//   a[8]  snapshot counter (w)
//   a[10] snapshot word a[2:1] (r)
//   a[12] FIFO head + pop (r) / UART transmit (w)
//   a[13] status {overflow, !fifo_empty, !tx_busy} (r) / clear overflow (w)
// Multiple set bits write every selected target and OR every read source.
// ----------------------------------------------------------------------------
module j1_iobus #(
    parameter int GPIO_W   = 8,
    parameter int LED_W    = 5,
    parameter int RX_DEPTH = 16,
    parameter int CNT_W    = 64
) (
    input  logic              clk,
    input  logic              resetq,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       dout,
    output logic [15:0]       io_din,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic [LED_W-1:0]  leds,
    input  logic              uart_rx_valid,
    input  logic [7:0]        uart_rx_data,
    output logic              uart_rx_ack,
    input  logic              uart_tx_busy,
    output logic              uart_tx_wr,
    output logic [7:0]        uart_tx_data
);

    localparam int AW = $clog2(RX_DEPTH);

    // ------------------------------------------------------------------
    // Registered bus stage
    // ------------------------------------------------------------------
    logic        io_rd_;
    logic        io_wr_;
    logic [15:0] a;
    logic [15:0] dout_;

    always_ff @(posedge clk) begin
        if (!resetq) begin
            io_rd_ <= 1'b0;
            io_wr_ <= 1'b0;
            a      <= '0;
            dout_  <= '0;
        end else begin
            io_rd_ <= io_rd;
            io_wr_ <= io_wr;
            dout_  <= dout;
            // The address holds between accesses so io_din stays stable.
            if (io_rd || io_wr)
                a <= mem_addr;
        end
    end

    logic wr_gpio_out, wr_gpio_oe, wr_leds, wr_snap, wr_tx, wr_clr_ovf;
    logic rd_pop;

    assign wr_gpio_out = io_wr_ & a[0];
    assign wr_gpio_oe  = io_wr_ & a[1];
    assign wr_leds     = io_wr_ & a[2];
    assign wr_snap     = io_wr_ & a[8];
    assign wr_tx       = io_wr_ & a[12];
    assign wr_clr_ovf  = io_wr_ & a[13];
    assign rd_pop      = io_rd_ & a[12];

    // ------------------------------------------------------------------
    // GPIO, LEDs
    // ------------------------------------------------------------------
    logic [GPIO_W-1:0] gpio_s1;
    logic [GPIO_W-1:0] gpio_s2;

    always_ff @(posedge clk) begin
        gpio_s1 <= gpio_in;
        gpio_s2 <= gpio_s1;
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            gpio_out <= '0;
            gpio_oe  <= '0;
            leds     <= '0;
        end else begin
            if (wr_gpio_out) gpio_out <= dout_[GPIO_W-1:0];
            if (wr_gpio_oe)  gpio_oe  <= dout_[GPIO_W-1:0];
            if (wr_leds)     leds     <= dout_[LED_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter and snapshot
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] snap;
    logic [63:0]      snap_pad;
    logic [15:0]      snap_word;

    always_ff @(posedge clk) begin
        if (!resetq) begin
            cnt  <= '0;
            snap <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
            // Captures the count present during the commit cycle (N+1).
            if (wr_snap) snap <= cnt;
        end
    end

    // Zero padding makes words beyond CNT_W/16 read as 0.
    assign snap_pad  = 64'(snap);
    assign snap_word = snap_pad[{a[2:1], 4'b0000} +: 16];

    // ------------------------------------------------------------------
    // RX FIFO
    //
    // Receive handshake: uart_rx_ack mirrors uart_rx_valid combinationally
    // (forced low in reset). Every acked byte is consumed: it is stored
    // unless the FIFO is full with no pop in the same cycle, in which case
    // it is dropped and the sticky overflow flag is set.
    // ------------------------------------------------------------------
    logic [7:0] mem [RX_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push;
    logic        ovf_set;
    logic        overflow;
    logic [7:0]  head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign uart_rx_ack = uart_rx_valid & resetq;
    // A pop from an empty FIFO is a no-op, so a same-cycle push still lands.
    assign pop     = rd_pop & ~fifo_empty;
    assign push    = uart_rx_valid & (~fifo_full | pop);
    assign ovf_set = uart_rx_valid & fifo_full & ~pop;
    assign head    = fifo_empty ? 8'd0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && resetq)
            mem[wr_ptr[AW-1:0]] <= uart_rx_data;
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            // Set takes priority over a same-cycle clear.
            if (ovf_set)
                overflow <= 1'b1;
            else if (wr_clr_ovf)
                overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // UART transmit
    // ------------------------------------------------------------------
    assign uart_tx_wr   = wr_tx & resetq;
    assign uart_tx_data = dout_[7:0];

    // ------------------------------------------------------------------
    // Read mux: OR of every selected source
    // ------------------------------------------------------------------
    logic [15:0] rdata;

    always_comb begin
        rdata = '0;
        if (a[0])  rdata = rdata | 16'(gpio_s2);
        if (a[1])  rdata = rdata | 16'(gpio_oe);
        if (a[2])  rdata = rdata | 16'(leds);
        if (a[10]) rdata = rdata | snap_word;
        if (a[12]) rdata = rdata | {8'd0, head};
        if (a[13]) rdata = rdata | {13'd0, overflow, ~fifo_empty, ~uart_tx_busy};
    end

    assign io_din = rdata;

endmodule
